// File: rtl/aurora_frame_pkg.sv
// Shared Aurora framing definitions: header IDs, control event codes and FSM encodings.
// Used by both the TX framer and the RX deframer.
package aurora_frame_pkg;

    localparam logic [31:0] HDR_CTRL = 32'h55aa_0001;
    localparam logic [31:0] HDR_EDS  = 32'h55aa_0002;
    localparam logic [31:0] HDR_ENC  = 32'h55aa_0003;
    localparam logic [31:0] HDR_FBC  = 32'h55aa_0004;

    // Control codes double as the bit index of the matching pending flag.
    localparam logic [1:0] CODE_EDS_END   = 2'd0;
    localparam logic [1:0] CODE_EDS_START = 2'd1;
    localparam logic [1:0] CODE_FBC_START = 2'd2;
    localparam logic [1:0] CODE_FBC_END   = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_HDR  = 4'b0010,
        ST_CTRL = 4'b0100,
        ST_DATA = 4'b1000
    } frame_state_t;

    typedef enum logic [1:0] {
        SRC_CTRL = 2'd0,
        SRC_ENC  = 2'd1,
        SRC_EDS  = 2'd2,
        SRC_FBC  = 2'd3
    } frame_src_t;

    function automatic logic [63:0] frame_hdr(input logic [31:0] id, input logic [15:0] len);
        return {16'h0, len, id};
    endfunction

endpackage

// File: rtl/aurora_chup_qualify.sv
// Channel-up debounce: tx_en asserts once CHANNEL_UP has been continuously high
// for CHUP_DLY cycles and drops on the first low sample.
module aurora_chup_qualify #(
    parameter int CHUP_DLY = 16
) (
    input  logic USER_CLK,
    input  logic RESET,
    input  logic CHANNEL_UP,
    output logic tx_en
);

    localparam int CNT_W = $clog2(CHUP_DLY + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge USER_CLK) begin
        if (RESET || !CHANNEL_UP) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(CHUP_DLY)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tx_en = (cnt == CNT_W'(CHUP_DLY));

endmodule

// File: rtl/aurora_64b66b_frame_tx.sv
// Aurora 64B66B user-side framer: arbitrates control events and EDS/FBC/encoder
// payload bursts into header-prefixed frames on the AXI4-Stream TX interface.
module aurora_64b66b_frame_tx
    import aurora_frame_pkg::*;
#(
    parameter int EDS_PAYLOAD_LEN = 1025,
    parameter int FBC_PAYLOAD_LEN = 1025,
    parameter int ENC_PAYLOAD_LEN = 4,
    parameter int CHUP_DLY        = 16
) (
    input  logic        USER_CLK,
    input  logic        RESET,
    input  logic        CHANNEL_UP,
    input  logic        eds_start_i,
    input  logic        eds_end_i,
    input  logic        fbc_start_i,
    input  logic        fbc_end_i,
    input  logic        eds_frame_req_i,
    input  logic        fbc_frame_req_i,
    input  logic        data_tvalid_i,
    input  logic [63:0] data_tdata_i,
    output logic        data_tready_o,
    input  logic        enc_frame_req_i,
    input  logic        enc_tvalid_i,
    input  logic [63:0] enc_tdata_i,
    output logic        enc_tready_o,
    output logic        tx_tvalid_o,
    output logic [63:0] tx_tdata_o,
    output logic [7:0]  tx_tkeep_o,
    output logic        tx_tlast_o,
    input  logic        tx_tready_i,
    output logic        tx_busy_o,
    output logic        frame_abort_o
);

    frame_state_t state, state_n;
    frame_src_t   sel, sel_n;
    logic [1:0]   code, code_n;
    logic [15:0]  len, len_n, cnt, cnt_n;
    logic [3:0]   pend, pend_set, pend_clr;
    logic         tvalid_n, tlast_n, abort_n, start;
    logic [63:0]  tdata_n, src_data;
    logic [31:0]  hdr_id;
    logic         tx_en, qualified, out_load, src_valid, src_ready, src_fire;

    aurora_chup_qualify #(.CHUP_DLY(CHUP_DLY)) u_chup (
        .USER_CLK   (USER_CLK),
        .RESET      (RESET),
        .CHANNEL_UP (CHANNEL_UP),
        .tx_en      (tx_en)
    );

    // Raw CHANNEL_UP is included so a channel drop aborts on the very edge it is seen.
    assign qualified = tx_en && CHANNEL_UP;
    assign out_load  = !tx_tvalid_o || tx_tready_i;
    assign pend_set  = {fbc_end_i, fbc_start_i, eds_start_i, eds_end_i};

    assign src_data  = (sel == SRC_ENC) ? enc_tdata_i : data_tdata_i;
    assign src_valid = (sel == SRC_ENC) ? enc_tvalid_i : data_tvalid_i;
    assign src_ready = qualified && (state == ST_DATA) && out_load && !(tx_tvalid_o && tx_tlast_o);
    assign src_fire  = src_ready && src_valid;

    assign data_tready_o = src_ready && ((sel == SRC_EDS) || (sel == SRC_FBC));
    assign enc_tready_o  = src_ready && (sel == SRC_ENC);
    assign tx_tkeep_o    = 8'hFF;
    assign tx_busy_o     = (state != ST_IDLE);

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        code_n   = code;
        len_n    = len;
        cnt_n    = cnt;
        tvalid_n = tx_tvalid_o;
        tdata_n  = tx_tdata_o;
        tlast_n  = tx_tlast_o;
        abort_n  = 1'b0;
        pend_clr = '0;
        start    = 1'b0;
        hdr_id   = HDR_CTRL;
        if (!qualified) begin
            state_n  = ST_IDLE;
            tvalid_n = 1'b0;
            tdata_n  = '0;
            tlast_n  = 1'b0;
            abort_n  = (state != ST_IDLE);
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pend != '0) begin
                        start = 1'b1;
                        sel_n = SRC_CTRL;
                        len_n = 16'd1;
                        for (int i = 3; i >= 0; i--) begin
                            if (pend[i]) code_n = i[1:0];
                        end
                    end else if (enc_frame_req_i) begin
                        start  = 1'b1;
                        sel_n  = SRC_ENC;
                        len_n  = 16'(ENC_PAYLOAD_LEN);
                        hdr_id = HDR_ENC;
                    end else if (eds_frame_req_i) begin
                        start  = 1'b1;
                        sel_n  = SRC_EDS;
                        len_n  = 16'(EDS_PAYLOAD_LEN);
                        hdr_id = HDR_EDS;
                    end else if (fbc_frame_req_i) begin
                        start  = 1'b1;
                        sel_n  = SRC_FBC;
                        len_n  = 16'(FBC_PAYLOAD_LEN);
                        hdr_id = HDR_FBC;
                    end
                    if (start) begin
                        tdata_n  = frame_hdr(hdr_id, len_n);
                        tvalid_n = 1'b1;
                        tlast_n  = 1'b0;
                        state_n  = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (tx_tready_i) begin
                        cnt_n = '0;
                        if (sel == SRC_CTRL) begin
                            tdata_n = {62'h0, code};
                            tlast_n = 1'b1;
                            state_n = ST_CTRL;
                        end else begin
                            tvalid_n = 1'b0;
                            state_n  = ST_DATA;
                        end
                    end
                end
                ST_CTRL: begin
                    if (tx_tready_i) begin
                        tvalid_n       = 1'b0;
                        tlast_n        = 1'b0;
                        pend_clr[code] = 1'b1;
                        state_n        = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (tx_tvalid_o && tx_tlast_o) begin
                        if (tx_tready_i) begin
                            tvalid_n = 1'b0;
                            tlast_n  = 1'b0;
                            state_n  = ST_IDLE;
                        end
                    end else if (src_fire) begin
                        tdata_n  = src_data;
                        tvalid_n = 1'b1;
                        cnt_n    = cnt + 16'd1;
                        tlast_n  = ((cnt + 16'd1) == len);
                    end else if (out_load) begin
                        tvalid_n = 1'b0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            state         <= ST_IDLE;
            sel           <= SRC_CTRL;
            code          <= '0;
            len           <= '0;
            cnt           <= '0;
            pend          <= '0;
            tx_tvalid_o   <= 1'b0;
            tx_tdata_o    <= '0;
            tx_tlast_o    <= 1'b0;
            frame_abort_o <= 1'b0;
        end else begin
            state         <= state_n;
            sel           <= sel_n;
            code          <= code_n;
            len           <= len_n;
            cnt           <= cnt_n;
            pend          <= (pend & ~pend_clr) | pend_set;
            tx_tvalid_o   <= tvalid_n;
            tx_tdata_o    <= tdata_n;
            tx_tlast_o    <= tlast_n;
            frame_abort_o <= abort_n;
        end
    end

endmodule

// File: tb/tb_aurora_64b66b_frame_tx.sv
// Scoreboard bench for the Aurora TX framer: expected words are queued as stimulus
// is applied and compared against every AXIS handshake on the TX port.
module tb_aurora_64b66b_frame_tx;

    localparam int EDS_LEN = 1025;
    localparam int FBC_LEN = 1025;
    localparam int ENC_LEN = 4;

    logic        USER_CLK = 1'b0;
    logic        RESET, CHANNEL_UP;
    logic        eds_start_i, eds_end_i, fbc_start_i, fbc_end_i;
    logic        eds_frame_req_i, fbc_frame_req_i, enc_frame_req_i;
    logic        data_tvalid_i, enc_tvalid_i, data_tready_o, enc_tready_o;
    logic [63:0] data_tdata_i, enc_tdata_i, tx_tdata_o;
    logic        tx_tvalid_o, tx_tlast_o, tx_tready_i, tx_busy_o, frame_abort_o;
    logic [7:0]  tx_tkeep_o;

    always #5 USER_CLK = ~USER_CLK;

    aurora_64b66b_frame_tx dut (
        .USER_CLK        (USER_CLK),
        .RESET           (RESET),
        .CHANNEL_UP      (CHANNEL_UP),
        .eds_start_i     (eds_start_i),
        .eds_end_i       (eds_end_i),
        .fbc_start_i     (fbc_start_i),
        .fbc_end_i       (fbc_end_i),
        .eds_frame_req_i (eds_frame_req_i),
        .fbc_frame_req_i (fbc_frame_req_i),
        .data_tvalid_i   (data_tvalid_i),
        .data_tdata_i    (data_tdata_i),
        .data_tready_o   (data_tready_o),
        .enc_frame_req_i (enc_frame_req_i),
        .enc_tvalid_i    (enc_tvalid_i),
        .enc_tdata_i     (enc_tdata_i),
        .enc_tready_o    (enc_tready_o),
        .tx_tvalid_o     (tx_tvalid_o),
        .tx_tdata_o      (tx_tdata_o),
        .tx_tkeep_o      (tx_tkeep_o),
        .tx_tlast_o      (tx_tlast_o),
        .tx_tready_i     (tx_tready_i),
        .tx_busy_o       (tx_busy_o),
        .frame_abort_o   (frame_abort_o)
    );

    logic [65:0] exp_q[$];
    logic [63:0] dq[$];
    logic [63:0] eq[$];
    int          total = 0;
    int          bad = 0;
    int          tx_count = 0;
    bit          rand_mode = 1'b0;
    bit          use_fbc = 1'b0;
    bit          prev_stall = 1'b0;
    logic [64:0] prev_word = '0;

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", tag, got, want);
        end
    endtask

    function automatic logic [65:0] ew(input logic last, input logic [63:0] d);
        return {1'b1, last, d};
    endfunction

    task automatic drive_src();
        data_tvalid_i   = (dq.size() > 0) && (!rand_mode || ($urandom_range(0, 3) != 0));
        data_tdata_i    = (dq.size() > 0) ? dq[0] : 64'h0;
        eds_frame_req_i = !use_fbc && (dq.size() >= EDS_LEN);
        fbc_frame_req_i = use_fbc && (dq.size() >= FBC_LEN);
        enc_tvalid_i    = (eq.size() > 0);
        enc_tdata_i     = (eq.size() > 0) ? eq[0] : 64'h0;
        enc_frame_req_i = (eq.size() >= ENC_LEN);
        tx_tready_i     = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Called just after a falling edge with inputs settled; returns after the next falling edge.
    task automatic cycle();
        #1;
        if (prev_stall)
            chk("stall_hold", {tx_tvalid_o, tx_tlast_o, tx_tdata_o}, {1'b1, prev_word});
        if (tx_tvalid_o && tx_tready_i) begin
            tx_count++;
            if (exp_q.size() == 0)
                chk("tx_unexpected", {tx_tvalid_o, tx_tlast_o, tx_tdata_o}, 66'h0);
            else
                chk("tx_word", {tx_tvalid_o, tx_tlast_o, tx_tdata_o}, exp_q.pop_front());
        end
        prev_stall = tx_tvalid_o && !tx_tready_i;
        prev_word  = {tx_tlast_o, tx_tdata_o};
        if (data_tvalid_i && data_tready_o && dq.size() > 0) void'(dq.pop_front());
        if (enc_tvalid_i && enc_tready_o && eq.size() > 0) void'(eq.pop_front());
        @(posedge USER_CLK);
        @(negedge USER_CLK);
        drive_src();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic push_ctrl(input logic [1:0] c);
        exp_q.push_back(ew(1'b0, 64'h0000_0001_55aa_0001));
        exp_q.push_back(ew(1'b1, {62'h0, c}));
    endtask

    task automatic add_frame(input logic [31:0] id, input int n, input logic [63:0] base, input bit to_enc);
        exp_q.push_back(ew(1'b0, {16'h0, 16'(n), id}));
        for (int i = 0; i < n; i++) begin
            if (to_enc) eq.push_back(base + 64'(i));
            else        dq.push_back(base + 64'(i));
            exp_q.push_back(ew(i == n - 1, base + 64'(i)));
        end
        drive_src();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk({"drain_", tag}, 66'(exp_q.size()), 66'h0);
    endtask

    task automatic wait_tx(input string tag, input int target, input int budget);
        int n = 0;
        while (tx_count < target && n < budget) begin
            cycle();
            n++;
        end
        chk({"reach_", tag}, 66'(tx_count >= target), 66'h1);
    endtask

    task automatic wait_first_valid(input string tag, input int want);
        int n = 0;
        while (!tx_tvalid_o && n < 100) begin
            cycle();
            n++;
        end
        chk(tag, 66'(n), 66'(want));
    endtask

    initial begin
        int base;
        RESET = 1'b1; CHANNEL_UP = 1'b0;
        eds_start_i = 1'b0; eds_end_i = 1'b0; fbc_start_i = 1'b0; fbc_end_i = 1'b0;
        @(negedge USER_CLK);
        drive_src();
        idle(3);
        chk("rst_tvalid", 66'(tx_tvalid_o), 66'h0);
        chk("rst_tlast", 66'(tx_tlast_o), 66'h0);
        chk("rst_tdata", 66'(tx_tdata_o), 66'h0);
        chk("rst_busy", 66'(tx_busy_o), 66'h0);
        chk("rst_abort", 66'(frame_abort_o), 66'h0);
        chk("rst_data_tready", 66'(data_tready_o), 66'h0);
        chk("rst_enc_tready", 66'(enc_tready_o), 66'h0);
        chk("tkeep", 66'(tx_tkeep_o), 66'hFF);

        // eds_start during channel qualification: header appears only after the debounce.
        RESET = 1'b0; CHANNEL_UP = 1'b1; eds_start_i = 1'b1;
        push_ctrl(2'd1);
        cycle();
        eds_start_i = 1'b0;
        wait_first_valid("chup_first_hdr", 16);
        wait_drain("ctrl_eds_start", 100);
        idle(10);

        // Full EDS frame, always ready.
        add_frame(32'h55aa_0002, EDS_LEN, 64'h0, 1'b0);
        wait_drain("eds_frame", 3000);
        idle(10);

        // EDS frame with random back-pressure and source gaps.
        rand_mode = 1'b1;
        add_frame(32'h55aa_0002, EDS_LEN, 64'hA5A5_0000_0000_0000, 1'b0);
        wait_drain("eds_random", 8000);
        rand_mode = 1'b0;
        drive_src();
        idle(10);

        // eds_end + encoder request while an EDS frame is running.
        base = tx_count;
        add_frame(32'h55aa_0002, EDS_LEN, 64'h1000_0000, 1'b0);
        wait_tx("eds_mid", base + 100, 500);
        eds_end_i = 1'b1;
        push_ctrl(2'd0);
        add_frame(32'h55aa_0003, ENC_LEN, 64'hE000_0000, 1'b1);
        cycle();
        eds_end_i = 1'b0;
        wait_drain("eds_end_enc", 3000);
        idle(10);

        // fbc_start and fbc_end together, then an FBC frame.
        use_fbc = 1'b1; fbc_start_i = 1'b1; fbc_end_i = 1'b1;
        push_ctrl(2'd2);
        push_ctrl(2'd3);
        cycle();
        fbc_start_i = 1'b0; fbc_end_i = 1'b0;
        add_frame(32'h55aa_0004, FBC_LEN, 64'hF000_0000, 1'b0);
        wait_drain("fbc", 3000);
        use_fbc = 1'b0;
        drive_src();
        idle(10);

        // Channel loss at EDS word 500 with an eds_start pending.
        base = tx_count;
        add_frame(32'h55aa_0002, EDS_LEN, 64'h2000_0000, 1'b0);
        wait_tx("abort_w100", base + 100, 500);
        eds_start_i = 1'b1;
        cycle();
        eds_start_i = 1'b0;
        push_ctrl(2'd1);
        wait_tx("abort_w500", base + 501, 1000);
        CHANNEL_UP = 1'b0;
        cycle();
        chk("abort_tvalid", 66'(tx_tvalid_o), 66'h0);
        chk("abort_pulse", 66'(frame_abort_o), 66'h1);
        chk("abort_busy", 66'(tx_busy_o), 66'h0);
        cycle();
        chk("abort_single", 66'(frame_abort_o), 66'h0);
        while (exp_q.size() > 0 && exp_q[0] != ew(1'b0, 64'h0000_0001_55aa_0001))
            void'(exp_q.pop_front());
        dq.delete();
        drive_src();
        idle(3);
        CHANNEL_UP = 1'b1;
        wait_first_valid("resend_first_hdr", 17);
        wait_drain("resend", 100);
        idle(10);

        // eds_start pulsed on the handshake edge of the previous eds_start frame.
        push_ctrl(2'd1);
        eds_start_i = 1'b1;
        cycle();
        eds_start_i = 1'b0;
        begin
            int n = 0;
            while (!(tx_tvalid_o && tx_tlast_o) && n < 50) begin
                cycle();
                n++;
            end
        end
        chk("ctrl_tlast_seen", 66'(tx_tvalid_o && tx_tlast_o), 66'h1);
        eds_start_i = 1'b1;
        push_ctrl(2'd1);
        cycle();
        eds_start_i = 1'b0;
        wait_drain("set_on_clear", 100);
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
